spart_tx: RTL and testbench

- Transmit-side responder for the processor's SPART send interface.
- The EX stage issues send/spart_addr/data. This block accepts the write, queues data bytes in a small FIFO, and serialises them on txd as 8N1 UART frames.
- Back-pressures the pipeline through full. The pipeline holds send asserted while full is high and re-presents it until it is accepted.

---
 rtl/spart_pkg.sv | 12 +
 rtl/spart_fifo.sv | 61 ++++++
 rtl/spart_tx.sv | 130 +++++++++++++
 tb/tb_spart_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART transmit path.
package spart_pkg;

  localparam logic [2:0] SPART_ADDR_TX  = 3'b000;
  localparam logic [2:0] SPART_ADDR_DIV = 3'b001;

  // 50 MHz / 9600 baud
  localparam int unsigned DEFAULT_DIV = 5208;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/spart_fifo.sv
// Byte-wide synchronous FIFO with registered full/empty flags.
module spart_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags come from count_d so they are aligned with the count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: accepts TX/divisor writes, queues bytes and sends 8N1 frames on txd.
module spart_tx #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = spart_pkg::DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [2:0]  spart_addr,
  input  logic [15:0] send_data,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        txd
);
  import spart_pkg::*;

  tx_state_t        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_eff;
  logic [DIV_W-1:0] bit_div_q, bit_div_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             txd_q, txd_d;
  logic             push, pop, baud_tc;
  logic [7:0]       fifo_rdata;

  assign push    = send && (spart_addr == SPART_ADDR_TX) && !full;
  assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
  assign baud_tc = (baud_q == '0);

  spart_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (send_data[7:0]),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DIV_W'(DEFAULT_DIV);
    end else if (send && (spart_addr == SPART_ADDR_DIV)) begin
      div_q <= send_data[DIV_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_div_d = bit_div_q;
    baud_d    = baud_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = fifo_rdata;
          bit_div_d = div_eff;
          baud_d    = div_eff - DIV_W'(1);
          txd_d     = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_tc) begin
          txd_d     = shift_q[0];
          bit_cnt_d = 3'd0;
          baud_d    = bit_div_q - DIV_W'(1);
          state_d   = DATA;
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d = bit_div_q - DIV_W'(1);
          if (bit_cnt_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (baud_tc) begin
          state_d = IDLE;
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_div_q <= '0;
      baud_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_div_q <= bit_div_d;
      baud_q    <= baud_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign txd  = txd_q;

endmodule

// File: tb/tb_spart_tx.sv
// Self-checking bench for spart_tx: vector table, directed corner cases and random traffic.
module tb_spart_tx;
  import spart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        send;
  logic [2:0]  spart_addr;
  logic [15:0] send_data;
  logic        full, empty, busy, txd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] div;
    logic [7:0]  b;
    int          bd;
  } vec_t;

  vec_t       tbl [5];
  logic [7:0] rb [6];
  int         rbd;

  spart_tx #(
    .DEPTH       (8),
    .DIV_W       (16),
    .DEFAULT_DIV (5208)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .send       (send),
    .spart_addr (spart_addr),
    .send_data  (send_data),
    .full       (full),
    .empty      (empty),
    .busy       (busy),
    .txd        (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ideal 8N1 line level t cycles after the start-bit falling edge.
  function automatic logic exp_txd(input logic [7:0] b, input int bd, input int t);
    int k;
    k = t / bd;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Holds the write until accepted; returns #1 after the accepting edge with send still high.
  task automatic wr(input logic [2:0] a, input logic [15:0] d, output int stalls);
    bit acc;
    acc    = 1'b0;
    stalls = 0;
    @(negedge clk);
    send       = 1'b1;
    spart_addr = a;
    send_data  = d;
    for (int i = 0; i < 2000; i++) begin
      acc = (a != SPART_ADDR_TX) || !full;
      @(posedge clk);
      if (acc) break;
      stalls++;
      @(negedge clk);
    end
    if (!acc) chk("wr_accept_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic bus_idle();
    send       = 1'b0;
    spart_addr = 3'b000;
    send_data  = 16'h0000;
  endtask

  task automatic check_frame(input string name, input logic [7:0] b, input int bd,
                             output int waited);
    int bad_wave, bad_busy;
    bad_wave = 0;
    bad_busy = 0;
    waited   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (txd !== 1'b0 && waited < 20 * bd + 100);
    if (txd !== 1'b0) begin
      chk({name, "_start_timeout"}, txd, 1'b0);
      return;
    end
    for (int t = 0; t < 10 * bd; t++) begin
      if (t > 0) @(negedge clk);
      if (txd !== exp_txd(b, bd, t)) bad_wave++;
      if (busy !== 1'b1) bad_busy++;
    end
    chk({name, "_wave_bad_samples"}, bad_wave, 0);
    chk({name, "_busy_bad_samples"}, bad_busy, 0);
    @(negedge clk);
    chk({name, "_gap_txd"}, txd, 1'b1);
    chk({name, "_gap_busy"}, busy, 1'b0);
  endtask

  task automatic wait_low(input string name, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txd !== 1'b0 && n < limit);
    chk({name, "_start"}, txd, 1'b0);
  endtask

  initial begin
    int s, w, low;

    rst = 1'b1;
    bus_idle();
    #3;
    chk("rst_txd", txd, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Divisor/byte table, including divisor 0 behaving as 1.
    tbl[0] = '{16'd4, 8'hA5, 4};
    tbl[1] = '{16'd0, 8'hFF, 1};
    tbl[2] = '{16'd1, 8'h3C, 1};
    tbl[3] = '{16'd3, 8'h81, 3};
    tbl[4] = '{16'd2, 8'h5A, 2};
    for (int i = 0; i < 5; i++) begin
      wr(SPART_ADDR_DIV, tbl[i].div, s);
      wr(SPART_ADDR_TX, {8'h00, tbl[i].b}, s);
      bus_idle();
      chk($sformatf("tbl%0d_empty_after_push", i), empty, 1'b0);
      check_frame($sformatf("tbl%0d", i), tbl[i].b, tbl[i].bd, w);
      chk($sformatf("tbl%0d_latency", i), w, 2);
    end

    // Unmapped addresses must leave FIFO, line and divisor (still 2) alone.
    wr(3'b101, 16'h0077, s);
    wr(3'b111, 16'h0001, s);
    bus_idle();
    repeat (4) @(negedge clk);
    chk("badaddr_empty", empty, 1'b1);
    chk("badaddr_txd", txd, 1'b1);
    chk("badaddr_busy", busy, 1'b0);
    wr(SPART_ADDR_TX, 16'h00C3, s);
    bus_idle();
    check_frame("badaddr_div_kept", 8'hC3, 2, w);

    // Fill the FIFO while the first frame runs; the 10th write must stall.
    fork
      begin
        int st, stall_early;
        stall_early = 0;
        wr(SPART_ADDR_DIV, 16'd2, st);
        for (int i = 0; i < 10; i++) begin
          wr(SPART_ADDR_TX, 16'(i), st);
          if (i < 9) stall_early += st;
          if (i == 8) chk("fifo_full_after_9", full, 1'b1);
          if (i == 9) begin
            chk("fifo_10th_stalled", (st > 0), 1'b1);
            chk("fifo_full_after_10", full, 1'b1);
          end
        end
        bus_idle();
        chk("fifo_no_early_stall", stall_early, 0);
      end
      begin
        int wt;
        for (int i = 0; i < 10; i++) check_frame($sformatf("fifo%0d", i), 8'(i), 2, wt);
      end
    join
    chk("fifo_drained_empty", empty, 1'b1);

    // Divisor change mid-frame applies only from the next frame.
    fork
      begin
        int st;
        wr(SPART_ADDR_DIV, 16'd4, st);
        wr(SPART_ADDR_TX, 16'h0096, st);
        wr(SPART_ADDR_TX, 16'h0069, st);
        bus_idle();
        repeat (12) @(negedge clk);
        wr(SPART_ADDR_DIV, 16'd8, st);
        bus_idle();
      end
      begin
        int wt;
        check_frame("middiv_old", 8'h96, 4, wt);
        check_frame("middiv_new", 8'h69, 8, wt);
      end
    join

    // Random bytes, divisors and write gaps.
    for (int r = 0; r < 3; r++) begin
      rbd = $urandom_range(1, 5);
      for (int i = 0; i < 6; i++) rb[i] = 8'($urandom);
      fork
        begin
          int st;
          wr(SPART_ADDR_DIV, 16'(rbd), st);
          for (int i = 0; i < 6; i++) begin
            wr(SPART_ADDR_TX, {8'h00, rb[i]}, st);
            bus_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
        end
        begin
          int wt;
          for (int i = 0; i < 6; i++) check_frame($sformatf("rnd%0d_%0d", r, i), rb[i], rbd, wt);
        end
      join
    end

    // Asynchronous reset during data bit 3 with a second byte still queued.
    wr(SPART_ADDR_DIV, 16'd4, s);
    wr(SPART_ADDR_TX, 16'h00A5, s);
    wr(SPART_ADDR_TX, 16'h003C, s);
    bus_idle();
    wait_low("arst", 20);
    repeat (17) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_txd", txd, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_empty", empty, 1'b1);
    chk("arst_full", full, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Divisor back at 5208: start bit of 8'h01 lasts exactly 5208 cycles.
    wr(SPART_ADDR_TX, 16'h0001, s);
    bus_idle();
    wait_low("defdiv", 10);
    low = 0;
    while (txd === 1'b0 && low < 6000) begin
      low++;
      @(negedge clk);
    end
    chk("defdiv_start_len", low, 5208);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
